// File: rtl/alu_rr_arbiter_pkg.sv
// Shared types and helpers for the two-port ALU round-robin arbiter.
// The legal-op helper is only referenced when ALU_ARB_OPCHECK_EN is defined.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Alternate encoding only exists for SUB (000) and SRA (101).
  function automatic logic op_legal(input logic [6:0] funct7, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (funct7 == F7_BASE) begin
      legal = 1'b1;
    end else if (funct7 == F7_ALT) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b101);
    end
    return legal;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester handshakes, response handshakes and ALU connections.
// slave = arbiter side, master = requesters plus ALU.
interface alu_rr_arbiter_if #(
  parameter int XLEN = 64
) ();

  logic            req0_valid;
  logic            req0_ready;
  logic [2:0]      req0_funct3;
  logic [6:0]      req0_funct7;
  logic [XLEN-1:0] req0_rs1;
  logic [XLEN-1:0] req0_rs2;

  logic            req1_valid;
  logic            req1_ready;
  logic [2:0]      req1_funct3;
  logic [6:0]      req1_funct7;
  logic [XLEN-1:0] req1_rs1;
  logic [XLEN-1:0] req1_rs2;

  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_rd;
  logic            rsp0_err;

  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_rd;
  logic            rsp1_err;

  logic [2:0]      alu_funct3;
  logic [6:0]      alu_funct7;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [XLEN-1:0] alu_rd;

  modport slave (
    input  req0_valid, req0_funct3, req0_funct7, req0_rs1, req0_rs2,
    output req0_ready,
    input  req1_valid, req1_funct3, req1_funct7, req1_rs1, req1_rs2,
    output req1_ready,
    output rsp0_valid, rsp0_rd, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_rd, rsp1_err,
    input  rsp1_ready,
    output alu_funct3, alu_funct7, alu_rs1, alu_rs2,
    input  alu_rd
  );

  modport master (
    output req0_valid, req0_funct3, req0_funct7, req0_rs1, req0_rs2,
    input  req0_ready,
    output req1_valid, req1_funct3, req1_funct7, req1_rs1, req1_rs2,
    input  req1_ready,
    input  rsp0_valid, rsp0_rd, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_rd, rsp1_err,
    output rsp1_ready,
    input  alu_funct3, alu_funct7, alu_rs1, alu_rs2,
    output alu_rd
  );

endinterface

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, ptr breaks ties.
// Purely combinational; grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] |  ptr);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared combinational RV64 ALU.
// Optional illegal-op screening is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_arbiter_if.slave   bus
);

  arb_state_e      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic [2:0]      f3_q, f3_d;
  logic [6:0]      f7_q, f7_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] rd_q, rd_d;
`ifdef ALU_ARB_OPCHECK_EN
  logic            err_q, err_d;
`endif

  logic [1:0]      req_valid;
  logic [1:0]      grant;
  logic [1:0]      rsp_ready;
  logic            accept;
  logic [2:0]      sel_f3;
  logic [6:0]      sel_f7;
  logic [XLEN-1:0] sel_rs1;
  logic [XLEN-1:0] sel_rs2;

  logic            rsp_valid [2];
  logic [XLEN-1:0] rsp_rd    [2];
  logic            rsp_err   [2];

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign accept  = (state_q == IDLE) && (grant != 2'b00);
  assign sel_f3  = grant[1] ? bus.req1_funct3 : bus.req0_funct3;
  assign sel_f7  = grant[1] ? bus.req1_funct7 : bus.req0_funct7;
  assign sel_rs1 = grant[1] ? bus.req1_rs1    : bus.req0_rs1;
  assign sel_rs2 = grant[1] ? bus.req1_rs2    : bus.req0_rs2;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
`ifdef ALU_ARB_OPCHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          f3_d    = sel_f3;
          f7_d    = sel_f7;
          rs1_d   = sel_rs1;
          rs2_d   = sel_rs2;
          state_d = EXEC;
`ifdef ALU_ARB_OPCHECK_EN
          // Illegal ops still load the ALU inputs but bypass EXEC entirely.
          if (op_legal(sel_f7, sel_f3)) begin
            err_d = 1'b0;
          end else begin
            err_d   = 1'b1;
            rd_d    = '0;
            state_d = RESP;
          end
`endif
        end
      end
      EXEC: begin
        rd_d    = bus.alu_rd;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      f3_q    <= '0;
      f7_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Non-owner response lanes are forced to zero so they never leak the result.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    localparam logic IDX = 1'(gi);
    assign rsp_valid[gi] = (state_q == RESP) && (owner_q == IDX);
    assign rsp_rd[gi]    = rsp_valid[gi] ? rd_q : '0;
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp_err[gi]   = rsp_valid[gi] & err_q;
`else
    assign rsp_err[gi]   = 1'b0;
`endif
  end

  assign bus.req0_ready = (state_q == IDLE) & grant[0];
  assign bus.req1_ready = (state_q == IDLE) & grant[1];

  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp0_rd    = rsp_rd[0];
  assign bus.rsp0_err   = rsp_err[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp1_rd    = rsp_rd[1];
  assign bus.rsp1_err   = rsp_err[1];

  assign bus.alu_funct3 = f3_q;
  assign bus.alu_funct7 = f7_q;
  assign bus.alu_rs1    = rs1_q;
  assign bus.alu_rs2    = rs2_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter with a behavioural RV64 ALU.
// Honours ALU_ARB_OPCHECK_EN for the illegal-op expectations.
module tb_alu_rr_arbiter;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic [63:0] alu_res;

  alu_rr_arbiter_if #(.XLEN(64)) bus ();

  alu_rr_arbiter #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: unsupported encodings return zero.
  always_comb begin
    alu_res = '0;
    if (bus.alu_funct7 == 7'b0000000) begin
      case (bus.alu_funct3)
        3'b000: alu_res = bus.alu_rs1 + bus.alu_rs2;
        3'b001: alu_res = bus.alu_rs1 << bus.alu_rs2[5:0];
        3'b010: alu_res = {63'd0, $signed(bus.alu_rs1) < $signed(bus.alu_rs2)};
        3'b011: alu_res = {63'd0, bus.alu_rs1 < bus.alu_rs2};
        3'b100: alu_res = bus.alu_rs1 ^ bus.alu_rs2;
        3'b101: alu_res = bus.alu_rs1 >> bus.alu_rs2[5:0];
        3'b110: alu_res = bus.alu_rs1 | bus.alu_rs2;
        default: alu_res = bus.alu_rs1 & bus.alu_rs2;
      endcase
    end else if (bus.alu_funct7 == 7'b0100000) begin
      if (bus.alu_funct3 == 3'b000) alu_res = bus.alu_rs1 - bus.alu_rs2;
      else if (bus.alu_funct3 == 3'b101) alu_res = $unsigned($signed(bus.alu_rs1) >>> bus.alu_rs2[5:0]);
    end
  end
  assign bus.alu_rd = alu_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] a, input logic [63:0] b);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_funct3 = f3; bus.req0_funct7 = f7;
      bus.req0_rs1 = a; bus.req0_rs2 = b;
    end else begin
      bus.req1_valid = v; bus.req1_funct3 = f3; bus.req1_funct7 = f7;
      bus.req1_rs1 = a; bus.req1_rs2 = b;
    end
  endtask

  initial begin
    int own;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_req(0, 1'b0, 3'b0, 7'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 3'b0, 7'b0, 64'd0, 64'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state
    next();
    mid();
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp0_err", bus.rsp0_err, 0);
    chk("rst_alu_rs1", bus.alu_rs1, 0);
    chk("rst_alu_funct7", bus.alu_funct7, 0);
    chk("rst_rsp0_rd", bus.rsp0_rd, 0);
    next();
    rst = 1'b0;

    // req0 ADD 5+7
    set_req(0, 1'b1, 3'b000, 7'b0000000, 64'd5, 64'd7);
    mid();
    chk("add_req0_ready", bus.req0_ready, 1);
    chk("add_req1_ready", bus.req1_ready, 0);
    chk("add_rsp1_valid_n", bus.rsp1_valid, 0);
    next();
    bus.req0_valid = 1'b0;
    mid();
    chk("add_rsp0_valid_n1", bus.rsp0_valid, 0);
    chk("add_alu_rs1", bus.alu_rs1, 64'd5);
    chk("add_rsp1_valid_n1", bus.rsp1_valid, 0);
    next();
    mid();
    chk("add_rsp0_valid_n2", bus.rsp0_valid, 1);
    chk("add_rsp0_rd", bus.rsp0_rd, 64'd12);
    chk("add_rsp0_err", bus.rsp0_err, 0);
    chk("add_rsp1_valid_n2", bus.rsp1_valid, 0);
    chk("add_rsp1_rd", bus.rsp1_rd, 0);
    next();

    // req1 SUB 3-5
    set_req(1, 1'b1, 3'b000, 7'b0100000, 64'd3, 64'd5);
    mid();
    chk("sub_rsp0_valid_gone", bus.rsp0_valid, 0);
    chk("sub_req1_ready", bus.req1_ready, 1);
    next();
    bus.req1_valid = 1'b0;
    mid();
    chk("sub_rsp1_valid_n1", bus.rsp1_valid, 0);
    next();
    mid();
    chk("sub_rsp1_valid_n2", bus.rsp1_valid, 1);
    chk("sub_rsp1_rd", bus.rsp1_rd, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_rsp0_valid", bus.rsp0_valid, 0);
    next();

    // Continuous contention from reset with XOR ops
    rst = 1'b1;
    next();
    rst = 1'b0;
    set_req(0, 1'b1, 3'b100, 7'b0000000, 64'hF0F0, 64'h0FF0);
    set_req(1, 1'b1, 3'b100, 7'b0000000, 64'hAAAA, 64'h5555);
    for (int c = 0; c < 12; c++) begin
      own = (c / 3) % 2;
      mid();
      chk($sformatf("rr_c%0d_req0_ready", c), bus.req0_ready, (c % 3 == 0) && (own == 0));
      chk($sformatf("rr_c%0d_req1_ready", c), bus.req1_ready, (c % 3 == 0) && (own == 1));
      chk($sformatf("rr_c%0d_rsp0_valid", c), bus.rsp0_valid, (c % 3 == 2) && (own == 0));
      chk($sformatf("rr_c%0d_rsp1_valid", c), bus.rsp1_valid, (c % 3 == 2) && (own == 1));
      if (c % 3 == 2) begin
        if (own == 0) chk($sformatf("rr_c%0d_rsp0_rd", c), bus.rsp0_rd, 64'hFF00);
        else          chk($sformatf("rr_c%0d_rsp1_rd", c), bus.rsp1_rd, 64'hFFFF);
      end
      next();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure on rsp0 with req1 waiting
    bus.rsp0_ready = 1'b0;
    set_req(0, 1'b1, 3'b000, 7'b0000000, 64'd100, 64'd23);
    mid();
    chk("bp_req0_ready", bus.req0_ready, 1);
    next();
    bus.req0_valid = 1'b0;
    set_req(1, 1'b1, 3'b110, 7'b0000000, 64'hF0, 64'h0F);
    mid();
    chk("bp_req1_ready_exec", bus.req1_ready, 0);
    next();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("bp_hold%0d_rsp0_valid", i), bus.rsp0_valid, 1);
      chk($sformatf("bp_hold%0d_rsp0_rd", i), bus.rsp0_rd, 64'd123);
      chk($sformatf("bp_hold%0d_req1_ready", i), bus.req1_ready, 0);
      next();
    end
    bus.rsp0_ready = 1'b1;
    mid();
    chk("bp_hs_rsp0_valid", bus.rsp0_valid, 1);
    chk("bp_hs_rsp0_rd", bus.rsp0_rd, 64'd123);
    chk("bp_hs_req1_ready", bus.req1_ready, 0);
    next();
    mid();
    chk("bp_after_req1_ready", bus.req1_ready, 1);
    chk("bp_after_rsp0_valid", bus.rsp0_valid, 0);
    next();
    bus.req1_valid = 1'b0;
    next();
    mid();
    chk("bp_rsp1_valid", bus.rsp1_valid, 1);
    chk("bp_rsp1_rd", bus.rsp1_rd, 64'hFF);
    next();

    // req0 XOR so the pointer moves to 1 before the reset test
    set_req(0, 1'b1, 3'b100, 7'b0000000, 64'h1234, 64'h00FF);
    mid();
    chk("pre_req0_ready", bus.req0_ready, 1);
    next();
    bus.req0_valid = 1'b0;
    next();
    mid();
    chk("pre_rsp0_rd", bus.rsp0_rd, 64'h12CB);
    next();

    // Reset during EXEC of req0 SLL
    set_req(0, 1'b1, 3'b001, 7'b0000000, 64'd1, 64'd4);
    mid();
    chk("rx_req0_ready", bus.req0_ready, 1);
    next();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    mid();
    chk("rx_exec_alu_rs2", bus.alu_rs2, 64'd4);
    next();
    rst = 1'b0;
    mid();
    chk("rx_rsp0_valid", bus.rsp0_valid, 0);
    chk("rx_rsp1_valid", bus.rsp1_valid, 0);
    chk("rx_rsp0_rd", bus.rsp0_rd, 0);
    chk("rx_rsp0_err", bus.rsp0_err, 0);
    chk("rx_alu_rs1", bus.alu_rs1, 0);
    chk("rx_alu_rs2", bus.alu_rs2, 0);
    chk("rx_alu_funct3", bus.alu_funct3, 0);
    chk("rx_req0_ready", bus.req0_ready, 0);
    next();
    set_req(0, 1'b1, 3'b000, 7'b0000000, 64'd2, 64'd2);
    set_req(1, 1'b1, 3'b000, 7'b0000000, 64'd9, 64'd9);
    mid();
    chk("rx_ptr_req0_ready", bus.req0_ready, 1);
    chk("rx_ptr_req1_ready", bus.req1_ready, 0);
    next();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mid();
    chk("rx_post_rsp0_valid", bus.rsp0_valid, 0);
    next();
    mid();
    chk("rx_post_rsp0_rd", bus.rsp0_rd, 64'd4);
    next();

    // Illegal funct7 on req0
    set_req(0, 1'b1, 3'b000, 7'b0000001, 64'd9, 64'd9);
    mid();
    chk("ill_req0_ready", bus.req0_ready, 1);
    next();
    bus.req0_valid = 1'b0;
    mid();
    chk("ill_alu_funct7", bus.alu_funct7, 64'd1);
`ifdef ALU_ARB_OPCHECK_EN
    chk("ill_rsp0_valid_n1", bus.rsp0_valid, 1);
    chk("ill_rsp0_rd", bus.rsp0_rd, 0);
    chk("ill_rsp0_err", bus.rsp0_err, 1);
    next();
`else
    chk("ill_rsp0_valid_n1", bus.rsp0_valid, 0);
    next();
    mid();
    chk("ill_rsp0_valid_n2", bus.rsp0_valid, 1);
    chk("ill_rsp0_rd", bus.rsp0_rd, 0);
    chk("ill_rsp0_err", bus.rsp0_err, 0);
    next();
`endif
    mid();
    chk("ill_done_rsp0_valid", bus.rsp0_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Two-port round-robin arbiter and sequencer for the shared 64-bit combinational RV64 ALU. It accepts ALU operations from two requesters, such as the integer pipe and a CSR/address helper, over valid/ready handshakes. It registers the operands into the ALU, captures the ALU result and returns it over a per-requester response handshake. It is the only block that drives the ALU's `funct3`/`funct7`/`rs1`/`rs2` inputs.

## Interface
Parameters:
- `XLEN`, 64: operand and result width. It must match the ALU.

Ports (`k` = 0, 1):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `reqk_valid`  in  1  requester k presents an operation.
- `reqk_ready`  out  1  operation accepted this cycle when high together with `reqk_valid`.
- `reqk_funct3`  in  3  ALU `funct3`.
- `reqk_funct7`  in  7  ALU `funct7`.
- `reqk_rs1`, `reqk_rs2`  in  XLEN  operands.
- `rspk_valid`  out  1  result available for requester k.
- `rspk_ready`  in  1  requester k consumes the result.
- `rspk_rd`  out  XLEN  result.
- `rspk_err`  out  1  illegal-operation flag (see Configuration).
- `alu_funct3`, `alu_funct7`, `alu_rs1`, `alu_rs2`  out  3/7/XLEN/XLEN  to the ALU; driven directly from the operand registers.
- `alu_rd`  in  XLEN  combinational ALU result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant: if only one `reqk_valid` is high, that requester wins. If both are high, the requester indicated by the priority pointer `ptr` wins.
  - `reqk_ready = (state==IDLE) & grant_k`. It is combinational from the valids and `ptr`; at most one ready is high.
  - On accept: latch `funct3`, `funct7`, `rs1`, `rs2` and the owner index, then go to EXEC.
- **EXEC** (one cycle): the ALU settles from the operand registers. At the cycle end, capture `alu_rd` into the result register and go to RESP.
- **RESP**
  - `rsp<owner>_valid=1`; the other `rspk_valid` is 0.
  - `rsp<owner>_rd` shows the result register. Non-owner `rd` outputs are 0.
  - On `rsp<owner>_ready`: go to IDLE and set `ptr` to the non-owner.
- Operand registers hold their values after EXEC. The ALU inputs change only on accept.
- No request is accepted outside IDLE. Requesters must hold valid and payload until ready.

## Timing
- Accept in cycle N. `rspk_valid` is high from cycle N+2 onward.
- Minimum initiation interval is 3 cycles per operation. There is no pipelining and at most one operation is in flight.
- Backpressure: RESP holds `rsp_valid`, `rd` and `err` stable until `rsp_ready`. There is no cycle limit.
- A request arriving while busy waits; its `ready` stays 0.
- Fairness: under continuous contention, grants alternate 0,1,0,1,...
- Reset values: state=IDLE, `ptr`=0, operand and result registers=0, all `ready`/`valid`/`err` outputs=0, `alu_*` outputs=0.
- Reset asserted in any state aborts the in-flight operation. No response is produced for it, and the next cycle is IDLE with reset values.
- Reset takes priority over every handshake in the same cycle.

## Configuration
- Macro: `ALU_ARB_OPCHECK_EN`.
- **Defined:** on accept, the pair {`funct7`, `funct3`} is checked.
  - Legal pairs: `funct7`=0000000 with any `funct3`; `funct7`=0100000 with `funct3` 000 or 101.
  - Illegal pair: skip EXEC and go straight from IDLE to RESP with `rd`=0 and `rsp<owner>_err=1` (response at N+1). The ALU inputs are still loaded.
- **Undefined:** no check is made, all operations take the EXEC path, and `rspk_err` is tied to 0. The port always exists.

## Structure
- Package `alu_arb_pkg`:
  - state enum (IDLE/EXEC/RESP);
  - `funct7` constants `F7_BASE`=0000000 and `F7_ALT`=0100000;
  - a legal-op function used under the macro.
- Sub-module `rr_arb2`: 2-way round-robin grant logic. Inputs are `valid[1:0]` and `ptr`; output is a one-hot `grant[1:0]`, purely combinational.
- The arbiter top holds the FSM, `ptr`, the registers and the response muxing.

## Test plan
- req0 ADD (`funct3`=000, `funct7`=0), `rs1`=5, `rs2`=7, `rsp0_ready`=1. Expect accept at N, `rsp0_valid` at N+2, `rd`=12, `rsp1_valid`=0 throughout.
- req1 SUB (`funct7`=0100000), `rs1`=3, `rs2`=5. Expect `rsp1_rd`=0xFFFF_FFFF_FFFF_FFFE at N+2.
- Both valid every cycle from reset with XOR ops. Expect grant order req0, req1, req0, req1, and each accept exactly 3 cycles after the previous one.
- `rsp0_ready` held low for 4 cycles in RESP. Expect `rsp0_valid`/`rd` stable, `req1_ready`=0 while req1 is valid, and req1 accepted the cycle after the response handshake.
- `rst` asserted during EXEC of req0 SLL (`rs1`=1, `rs2`=4). Expect no `rsp0_valid`, all outputs 0 the next cycle, and `ptr`=0.
- With the macro defined: req0 `funct7`=0000001, `funct3`=000. Expect `rsp0_valid` at N+1 with `rd`=0 and `err`=1. Without the macro: `rd`=0 at N+2 and `err`=0.
